keypad_scan: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment display driver.
- Scans a 4x4 active-low matrix keypad and debounces the pressed key.
- Emits a 4-bit hex key code with a one-cycle valid strobe.
- Shifts each accepted digit into a 32-bit hex register that feeds the display's hex input word.

---
 rtl/keypad_scan_if.sv | 34 +++
 rtl/keypad_scan.sv | 151 +++++++++++++++
 tb/tb_keypad_scan.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: groups the keypad matrix lines and the decoded-key outputs.
//   col       : keypad column sense, active-low, asynchronous to clk
//   clr       : synchronous clear of hex_out (one-cycle pulse)
//   row       : keypad row drive, active-low one-hot
//   key_valid : one-cycle strobe, new key accepted
//   key_code  : code of the last accepted key
//   hex_out   : last 8 accepted digits, newest in [3:0]
// master = environment side (keypad, clear source); slave = keypad_scan itself.
interface keypad_scan_if;
    logic [3:0]  col;
    logic        clr;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] hex_out;

    modport master (
        output col,
        output clr,
        input  row,
        input  key_valid,
        input  key_code,
        input  hex_out
    );

    modport slave (
        input  col,
        input  clr,
        output row,
        output key_valid,
        output key_code,
        output hex_out
    );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low matrix keypad, debounces press and release,
// and emits a hex key code with a one-cycle strobe. Accepted digits are shifted
// into a 32-bit word that feeds a seven-segment display driver.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   kp   : keypad_scan_if.slave (col, clr in; row, key_valid, key_code, hex_out out)
// Parameters:
//   N  : clk cycles per scan tick (>= 4)
//   DB : consecutive scan ticks a key state must hold to be accepted (>= 1)
module keypad_scan #(
    parameter int unsigned N  = 100000,
    parameter int unsigned DB = 20
) (
    input  logic         clk,
    input  logic         rstn,
    keypad_scan_if.slave kp
);

    localparam int unsigned DW = $clog2(N);
    localparam int unsigned CW = $clog2(DB + 1);

    typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

    state_e          state_q;
    logic [DW-1:0]   div_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      sync_q;   // first synchronizer stage
    logic [3:0]      cs_q;     // synchronized column sense
    logic [1:0]      r_q;
    logic [3:0]      row_q;
    logic [3:0]      pat_q;    // column pattern latched on entry to debounce
    logic [1:0]      c_q;
    logic            key_valid_q;
    logic [3:0]      key_code_q;
    logic [31:0]     hex_q;

    logic            tick;
    logic            single;
    logic [1:0]      c;
    logic [3:0]      code;

    assign tick = (div_q == DW'(N - 1));

    // Exactly one column low counts as a key; anything else is treated as no key.
    always_comb begin
        single = 1'b1;
        c      = 2'd0;
        case (cs_q)
            4'b1110: c = 2'd0;
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            4'b0111: c = 2'd3;
            default: single = 1'b0;
        endcase
    end

    // In SCAN the key is accepted straight away only when DB == 1.
    always_comb begin
        code = (state_q == StScan) ? {r_q, c} : {r_q, c_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StScan;
            div_q       <= '0;
            cnt_q       <= '0;
            sync_q      <= 4'b1111;
            cs_q        <= 4'b1111;
            r_q         <= 2'd0;
            row_q       <= 4'b1110;
            pat_q       <= 4'b1111;
            c_q         <= 2'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            hex_q       <= '0;
        end else begin
            sync_q      <= kp.col;
            cs_q        <= sync_q;
            key_valid_q <= 1'b0;
            div_q       <= tick ? '0 : div_q + DW'(1);

            if (tick) begin
                case (state_q)
                    StScan: begin
                        if (single) begin
                            pat_q <= cs_q;
                            c_q   <= c;
                            if (DB == 1) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= code;
                                hex_q       <= {hex_q[27:0], code};
                                cnt_q       <= '0;
                                state_q     <= StHeld;
                            end else begin
                                cnt_q   <= CW'(1);
                                state_q <= StDebounce;
                            end
                        end else begin
                            r_q   <= r_q + 2'd1;
                            row_q <= {row_q[2:0], row_q[3]};
                        end
                    end
                    StDebounce: begin
                        if (cs_q == pat_q) begin
                            if (cnt_q == CW'(DB - 1)) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= code;
                                hex_q       <= {hex_q[27:0], code};
                                cnt_q       <= '0;
                                state_q     <= StHeld;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end else begin
                            // Bounce: rescan the same row.
                            cnt_q   <= '0;
                            state_q <= StScan;
                        end
                    end
                    StHeld: begin
                        if (cs_q == 4'b1111) begin
                            if (cnt_q == CW'(DB - 1)) begin
                                cnt_q   <= '0;
                                state_q <= StScan;
                                r_q     <= r_q + 2'd1;
                                row_q   <= {row_q[2:0], row_q[3]};
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    default: state_q <= StScan;
                endcase
            end

            // Clear overrides any shift applied in the same cycle.
            if (kp.clr) begin
                hex_q <= '0;
            end
        end
    end

    assign kp.row       = row_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.hex_out   = hex_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_fail;
    int   vcount;
    logic [31:0] exp_hex;

    keypad_scan_if kp ();

    keypad_scan #(
        .N  (4),
        .DB (3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .kp   (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) vcount++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge where row has just switched to target (divider at 0).
    task automatic wait_row(input logic [3:0] target);
        logic [3:0] prev;
        bit         found;
        prev  = kp.row;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (kp.row == target && prev != target) found = 1'b1;
            prev = kp.row;
        end
        check("wait_row", {31'd0, found}, 32'd1);
    endtask

    task automatic press_key(input logic [3:0] code, input int hold_ticks, input bit clr_hit);
        logic [3:0] trow;
        logic [3:0] tcol;
        int         v0;
        trow = ~(4'b0001 << code[3:2]);
        tcol = ~(4'b0001 << code[1:0]);
        wait_row(trow);
        v0 = vcount;
        kp.col = tcol;
        repeat (11) @(negedge clk);
        if (clr_hit) kp.clr = 1'b1;
        @(negedge clk);
        kp.clr = 1'b0;
        exp_hex = clr_hit ? 32'd0 : {exp_hex[27:0], code};
        check("accept_valid", {31'd0, kp.key_valid}, 32'd1);
        check("accept_code", {28'd0, kp.key_code}, {28'd0, code});
        check("accept_hex", kp.hex_out, exp_hex);
        check("row_frozen", {28'd0, kp.row}, {28'd0, trow});
        repeat ((hold_ticks - 3) * 4) @(negedge clk);
        kp.col = 4'hF;
        repeat (12) @(negedge clk);
        check("row_after_release", {28'd0, kp.row}, {28'd0, trow[2:0], trow[3]});
        check("one_pulse", vcount - v0, 32'd1);
    endtask

    initial begin
        int v0;
        n_cmp   = 0;
        n_fail  = 0;
        vcount  = 0;
        exp_hex = 32'd0;
        rstn    = 1'b0;
        kp.col  = 4'hF;
        kp.clr  = 1'b0;

        // Reset values and idle scanning.
        repeat (3) @(negedge clk);
        check("rst_row", {28'd0, kp.row}, 32'hE);
        check("rst_valid", {31'd0, kp.key_valid}, 32'd0);
        check("rst_code", {28'd0, kp.key_code}, 32'd0);
        check("rst_hex", kp.hex_out, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("scan_row0", {28'd0, kp.row}, 32'hE);
        repeat (2) @(negedge clk);
        check("scan_row1", {28'd0, kp.row}, 32'hD);
        repeat (4) @(negedge clk);
        check("scan_row2", {28'd0, kp.row}, 32'hB);
        repeat (4) @(negedge clk);
        check("scan_row3", {28'd0, kp.row}, 32'h7);
        repeat (4) @(negedge clk);
        check("scan_wrap", {28'd0, kp.row}, 32'hE);
        check("idle_no_valid", vcount, 32'd0);

        // Clean press: row 1, column 2 -> 0x6.
        press_key(4'h6, 3, 1'b0);
        check("hex_after_6", kp.hex_out, 32'h0000_0006);

        // Bounce on row 0: one tick low, then released.
        wait_row(4'hE);
        v0 = vcount;
        kp.col = 4'b1110;
        repeat (4) @(negedge clk);
        kp.col = 4'hF;
        repeat (4) @(negedge clk);
        check("bounce_row_held", {28'd0, kp.row}, 32'hE);
        repeat (4) @(negedge clk);
        check("bounce_row_next", {28'd0, kp.row}, 32'hD);
        check("bounce_no_valid", vcount - v0, 32'd0);
        press_key(4'h0, 3, 1'b0);
        check("hex_after_0", kp.hex_out, 32'h0000_0060);

        // Digit stream 1..9; oldest digits shift out.
        for (int d = 1; d <= 9; d++) press_key(4'(d), 3, 1'b0);
        check("hex_stream", kp.hex_out, 32'h2345_6789);

        // Two columns low: ignored, scanning continues.
        wait_row(4'hE);
        v0 = vcount;
        kp.col = 4'b0011;
        repeat (4) @(negedge clk);
        check("multi_row1", {28'd0, kp.row}, 32'hD);
        repeat (4) @(negedge clk);
        check("multi_row2", {28'd0, kp.row}, 32'hB);
        kp.col = 4'hF;
        check("multi_no_valid", vcount - v0, 32'd0);
        check("multi_hex", kp.hex_out, 32'h2345_6789);

        // Key held for 50 ticks gives one strobe.
        press_key(4'h5, 50, 1'b0);
        check("hex_after_hold", kp.hex_out, 32'h3456_7895);

        // Clear colliding with an accept of 0xA.
        press_key(4'hA, 3, 1'b1);
        check("hex_after_clr_hit", kp.hex_out, 32'd0);

        // Plain clear pulse.
        press_key(4'hB, 3, 1'b0);
        check("hex_before_clr", kp.hex_out, 32'h0000_000B);
        @(negedge clk);
        kp.clr = 1'b1;
        @(negedge clk);
        kp.clr = 1'b0;
        check("hex_after_clr", kp.hex_out, 32'd0);

        // Asynchronous reset while debouncing row 2 column 3.
        wait_row(4'hB);
        kp.col = 4'b0111;
        repeat (6) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_row", {28'd0, kp.row}, 32'hE);
        check("async_rst_valid", {31'd0, kp.key_valid}, 32'd0);
        check("async_rst_code", {28'd0, kp.key_code}, 32'd0);
        check("async_rst_hex", kp.hex_out, 32'd0);
        kp.col = 4'hF;
        @(negedge clk);
        rstn = 1'b1;
        v0 = vcount;
        repeat (40) @(negedge clk);
        check("no_accept_after_rst", vcount - v0, 32'd0);
        check("hex_after_rst", kp.hex_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
